// File: rtl/div_sequencer_if.sv
// Handshake and result bundle between the execute-stage DIV issue logic and
// the divide sequencer.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_mf_hi;
  logic             is_mf_lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall_mf;
  logic             stall_div;

  modport slave (
    input  start, dividend, divisor, is_mf_hi, is_mf_lo,
    output hi, lo, busy, stall_mf, stall_div
  );

  modport master (
    output start, dividend, divisor, is_mf_hi, is_mf_lo,
    input  hi, lo, busy, stall_mf, stall_div
  );
endinterface

// File: rtl/div_sequencer.sv
// Signed restoring divider with HI/LO result registers and hazard stalls
// for the pipelined MIPS core: IDLE -> RUN (WIDTH iterations) -> FIX -> IDLE.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  div_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_C = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction

  // Next-state and datapath decisions for every FSM state.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;

    // rem < divisor magnitude always holds, so the shifted value never needs bit WIDTH.
    shift_s = {rem_q, quo_q[WIDTH-1]};
    trial_s = shift_s - {1'b0, dvs_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvs_d     = magnitude(bus.divisor);
          quo_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rem_neg_d = bus.dividend[WIDTH-1];
          rem_d     = {WIDTH{1'b0}};
          cnt_d     = {CW{1'b0}};
          busy_d    = 1'b1;
          if (bus.divisor == {WIDTH{1'b0}}) begin
            // quo holds the raw dividend so FIX can hand it to HI untouched.
            dbz_d   = 1'b1;
            quo_d   = bus.dividend;
            state_d = ST_FIX;
          end else begin
            dbz_d   = 1'b0;
            quo_d   = magnitude(bus.dividend);
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial_s[WIDTH]};
        rem_d = trial_s[WIDTH] ? shift_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == LAST_C) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FIX: begin
        if (dbz_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = quo_q;
        end else begin
          lo_d = quo_neg_q ? negate(quo_q) : quo_q;
          hi_d = rem_neg_q ? negate(rem_q) : rem_q;
        end
        cnt_d   = {CW{1'b0}};
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any divide in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  // The start term catches a DIV in E and an MF in D arriving together.
  assign bus.stall_mf  = (busy_q | bus.start) & (bus.is_mf_hi | bus.is_mf_lo);
  assign bus.stall_div = busy_q & bus.start;

endmodule
